// File: rtl/cnn_lcd_system_pkg.sv
// Shared geometry, pixel formats and the Gaussian kernel for the
// camera -> filter -> RGB565 -> LCD-buffer image path.
package cnn_lcd_system_pkg;

   localparam int IMG_WIDTH    = 480;
   localparam int IMG_HEIGHT   = 272;
   localparam int IMG_DEPTH    = IMG_WIDTH * IMG_HEIGHT;
   localparam int FRAME_ADDR_W = 17;

   localparam int RGB888_W = 24;
   localparam int RGB565_W = 16;
   localparam int CH_W     = 8;

   localparam int SUM_W        = 12;
   localparam int KERNEL_SHIFT = 4;

   // Rows top..bottom, columns left..right; weights sum to 16.
   localparam logic [2:0] KERNEL [3][3] = '{
      '{3'd1, 3'd2, 3'd1},
      '{3'd2, 3'd4, 3'd2},
      '{3'd1, 3'd2, 3'd1}
   };

   function automatic logic [RGB565_W-1:0] to_rgb565(
      input logic [RGB888_W-1:0] p
   );
      return {p[23:19], p[15:10], p[7:3]};
   endfunction

endpackage

// File: rtl/cnn_lcd_system_cnn.sv
// Frame memory, 3x3 line-buffer Gaussian/bypass filter, RGB565 stage and
// output buffer; streams one frame per reset release.
module cnn_lcd_system_cnn
   import cnn_lcd_system_pkg::*;
#(
   parameter int ADDR_W = FRAME_ADDR_W,
   parameter int DATA_W = RGB888_W,
   parameter int WIDTH  = IMG_WIDTH,
   parameter int HEIGHT = IMG_HEIGHT,
   parameter int DEPTH  = IMG_DEPTH
) (
   input logic clk_i,
   input logic rst_i,
   input logic mode_i
);

   localparam int PW = ADDR_W + 1;
   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);
   localparam logic [PW-1:0] LAST_P    = PW'(DEPTH + WIDTH);
   localparam logic [PW-1:0] FIRST_OUT = PW'(WIDTH + 1);

   logic [DATA_W-1:0] rFrame [0:DEPTH-1];
   logic [DATA_W-1:0] rom_q;
   logic              cam_we;
   logic [ADDR_W-1:0] cam_waddr;
   logic [DATA_W-1:0] cam_wdata;

   logic [PW-1:0] p_q, p_d;
   logic [XW-1:0] px_q, px_d, px1_q;
   logic          run, in_img;
   logic          first_q, mode_q;
   logic          v1_q, pix1_q, emit1_q;

   logic [DATA_W-1:0] lb0_q [0:WIDTH-1];
   logic [DATA_W-1:0] lb1_q [0:WIDTH-1];
   logic [DATA_W-1:0] win_q [0:2][0:2];
   logic [DATA_W-1:0] pin;

   logic              win_v_q;
   logic [XW-1:0]     ox_q, ox_d;
   logic [YW-1:0]     oy_q, oy_d;
   logic [ADDR_W-1:0] oidx_q;

   logic [2:0]        row_ok, col_ok;
   logic [SUM_W-1:0]  acc;
   logic [DATA_W-1:0] filt, fpix;

   logic                wr_v;
   logic [ADDR_W-1:0]   wr_addr;
   logic [RGB565_W-1:0] wr_data;
   logic [ADDR_W-1:0]   lcd_raddr;
   logic [RGB565_W-1:0] unused_lcd_rdata;

   // Camera capture port of the frame memory is idle in this configuration.
   assign cam_we    = 1'b0;
   assign cam_waddr = '0;
   assign cam_wdata = '0;
   assign lcd_raddr = '0;

   always_ff @(posedge clk_i) begin
      if (cam_we) begin
         rFrame[cam_waddr] <= cam_wdata;
      end
      if (run && in_img) begin
         rom_q <= rFrame[p_q[ADDR_W-1:0]];
      end
   end

   // Pushes run past the frame by WIDTH+1 zero pixels to flush the window.
   always_comb begin
      run    = (p_q <= LAST_P);
      in_img = (p_q < PW'(DEPTH));
      p_d    = p_q;
      px_d   = px_q;
      if (run) begin
         p_d  = p_q + PW'(1);
         px_d = (px_q == XW'(WIDTH - 1)) ? '0 : px_q + XW'(1);
      end
      ox_d = (ox_q == XW'(WIDTH - 1)) ? '0 : ox_q + XW'(1);
      oy_d = oy_q;
      if (ox_q == XW'(WIDTH - 1)) begin
         oy_d = (oy_q == YW'(HEIGHT - 1)) ? '0 : oy_q + YW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         p_q     <= '0;
         px_q    <= '0;
         px1_q   <= '0;
         first_q <= 1'b1;
         mode_q  <= 1'b0;
         v1_q    <= 1'b0;
         pix1_q  <= 1'b0;
         emit1_q <= 1'b0;
         win_v_q <= 1'b0;
         ox_q    <= '0;
         oy_q    <= '0;
         oidx_q  <= '0;
      end else begin
         p_q     <= p_d;
         px_q    <= px_d;
         px1_q   <= px_q;
         first_q <= 1'b0;
         if (first_q) begin
            mode_q <= mode_i;
         end
         v1_q    <= run;
         pix1_q  <= run && in_img;
         emit1_q <= run && (p_q >= FIRST_OUT);
         win_v_q <= v1_q && emit1_q;
         if (win_v_q) begin
            ox_q   <= ox_d;
            oy_q   <= oy_d;
            oidx_q <= oidx_q + ADDR_W'(1);
         end
      end
   end

   assign pin = pix1_q ? rom_q : '0;

   // Window center after pushing pixel p is pixel p-WIDTH-1.
   always_ff @(posedge clk_i) begin
      if (v1_q) begin
         lb0_q[px1_q] <= pin;
         lb1_q[px1_q] <= lb0_q[px1_q];
         for (int r = 0; r < 3; r++) begin
            win_q[r][0] <= win_q[r][1];
            win_q[r][1] <= win_q[r][2];
         end
         win_q[0][2] <= lb1_q[px1_q];
         win_q[1][2] <= lb0_q[px1_q];
         win_q[2][2] <= pin;
      end
   end

   always_comb begin
      row_ok = {oy_q != YW'(HEIGHT - 1), 1'b1, oy_q != '0};
      col_ok = {ox_q != XW'(WIDTH - 1), 1'b1, ox_q != '0};
      filt   = '0;
      acc    = '0;
      for (int ch = 0; ch < 3; ch++) begin
         acc = '0;
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               if (row_ok[r] && col_ok[c]) begin
                  acc = acc + SUM_W'(KERNEL[r][c])
                            * SUM_W'(win_q[r][c][ch*CH_W +: CH_W]);
               end
            end
         end
         filt[ch*CH_W +: CH_W] = acc[SUM_W-1:KERNEL_SHIFT];
      end
      fpix = mode_q ? win_q[1][1] : filt;
   end

   cnn_lcd_system_rgb565 #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_RGB888ToRGB565 (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (win_v_q),
      .addr_i  (oidx_q),
      .pix_i   (fpix),
      .valid_o (wr_v),
      .addr_o  (wr_addr),
      .data_o  (wr_data)
   );

   cnn_lcd_system_oufbuf #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_OufBuf_DPSram_RGB565 (
      .clk_i    (clk_i),
      .a_we_i   (wr_v),
      .a_addr_i (wr_addr),
      .a_data_i (wr_data),
      .b_addr_i (lcd_raddr),
      .b_data_o (unused_lcd_rdata)
   );

endmodule

// File: rtl/cnn_lcd_system_oufbuf.sv
// RGB565 output frame buffer: port A writes, port B read for the LCD side.
module cnn_lcd_system_oufbuf
   import cnn_lcd_system_pkg::*;
#(
   parameter int ADDR_W = FRAME_ADDR_W,
   parameter int DEPTH  = IMG_DEPTH
) (
   input  logic                clk_i,
   input  logic                a_we_i,
   input  logic [ADDR_W-1:0]   a_addr_i,
   input  logic [RGB565_W-1:0] a_data_i,
   input  logic [ADDR_W-1:0]   b_addr_i,
   output logic [RGB565_W-1:0] b_data_o
);

   logic [RGB565_W-1:0] rOufBuf [0:DEPTH-1];
   logic [RGB565_W-1:0] b_data_q;

   always_ff @(posedge clk_i) begin
      if (a_we_i) begin
         rOufBuf[a_addr_i] <= a_data_i;
      end
      b_data_q <= rOufBuf[b_addr_i];
   end

   assign b_data_o = b_data_q;

endmodule

// File: rtl/cnn_lcd_system_rgb565.sv
// RGB888 -> RGB565 pipeline register; also owns the sticky frame-done flag.
module cnn_lcd_system_rgb565
   import cnn_lcd_system_pkg::*;
#(
   parameter int ADDR_W = FRAME_ADDR_W,
   parameter int DEPTH  = IMG_DEPTH
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                valid_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [RGB888_W-1:0] pix_i,
   output logic                valid_o,
   output logic [ADDR_W-1:0]   addr_o,
   output logic [RGB565_W-1:0] data_o
);

   logic                valid_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [RGB565_W-1:0] data_q;
   logic                done_valid_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q        <= 1'b0;
         done_valid_reg <= 1'b0;
      end else begin
         valid_q <= valid_i;
         // Set on the edge that writes the last pixel, visible the cycle after.
         if (valid_q && addr_q == ADDR_W'(DEPTH - 1)) begin
            done_valid_reg <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      addr_q <= addr_i;
      data_q <= to_rgb565(pix_i);
   end

   assign valid_o = valid_q;
   assign addr_o  = addr_q;
   assign data_o  = data_q;

endmodule

// File: rtl/cnn_lcd_system_top.sv
// Simulation-configuration top: frame memory through filter into the
// RGB565 LCD frame buffer, once per reset release.
module cnn_lcd_system_top
   import cnn_lcd_system_pkg::*;
#(
   parameter int    ADDR_W    = FRAME_ADDR_W,
   parameter int    DATA_W    = RGB888_W,
   parameter int    WIDTH     = IMG_WIDTH,
   parameter int    HEIGHT    = IMG_HEIGHT,
   parameter int    DEPTH     = IMG_DEPTH,
   parameter string INIT_FILE = "in_rgb888.txt"
) (
   input logic        PL_CLK_100MHZ,
   input logic        RstButton,
   input logic [31:0] iReg0,
   input logic [31:0] iReg1,
   input logic [31:0] iReg2,
   input logic [31:0] iReg3
);

   logic unused_regs;

   assign unused_regs = ^{iReg0[31:1], iReg1, iReg2, iReg3};

   cnn_lcd_system_cnn #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .DEPTH  (DEPTH)
   ) u_cnn_top (
      .clk_i  (PL_CLK_100MHZ),
      .rst_i  (RstButton),
      .mode_i (iReg0[0])
   );

endmodule

// File: tb/tb_cnn_lcd_system_top.sv
// Directed bench for cnn_lcd_system_top on a reduced 20x14 frame.
module tb_cnn_lcd_system_top;

   localparam int W      = 20;
   localparam int H      = 14;
   localparam int D      = W * H;
   localparam int BUDGET = D + W + 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] ireg0 = 32'h0;
   logic [31:0] ireg1 = 32'hDEAD_BEEF;
   logic [31:0] ireg2 = 32'h1234_5678;
   logic [31:0] ireg3 = 32'hFFFF_FFFF;
   logic        done;

   int n_assert = 0;
   int n_fail   = 0;
   int done_cyc;

   logic [23:0] img   [0:D-1];
   logic [15:0] exp_q [0:D-1];

   cnn_lcd_system_top #(
      .WIDTH  (W),
      .HEIGHT (H),
      .DEPTH  (D)
   ) dut (
      .PL_CLK_100MHZ (clk),
      .RstButton     (rst),
      .iReg0         (ireg0),
      .iReg1         (ireg1),
      .iReg2         (ireg2),
      .iReg3         (ireg3)
   );

   assign done = dut.u_cnn_top.u_RGB888ToRGB565.done_valid_reg;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] want);
      n_assert++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
   endtask

   function automatic logic [15:0] f565(input logic [23:0] p);
      return {p[23:19], p[15:10], p[7:3]};
   endfunction

   task automatic build_gauss();
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            logic [23:0] o;
            o = '0;
            for (int ch = 0; ch < 3; ch++) begin
               int s;
               s = 0;
               for (int dy = -1; dy <= 1; dy++) begin
                  for (int dx = -1; dx <= 1; dx++) begin
                     int xx, yy;
                     xx = x + dx;
                     yy = y + dy;
                     if (xx >= 0 && xx < W && yy >= 0 && yy < H)
                        s += (dx == 0 ? 2 : 1) * (dy == 0 ? 2 : 1)
                             * int'(img[yy*W+xx][ch*8 +: 8]);
                  end
               end
               o[ch*8 +: 8] = 8'(s >> 4);
            end
            exp_q[y*W+x] = f565(o);
         end
      end
   endtask

   task automatic begin_frame(input logic mode, input string tag);
      @(negedge clk);
      rst   = 1'b1;
      ireg0 = 32'hFFFF_FFFE | 32'(mode);
      @(posedge clk);
      #1;
      chk({tag, "_rst_done"}, 32'(done), 32'd0);
      chk({tag, "_rst_addr"}, 32'(dut.u_cnn_top.p_q), 32'd0);
      @(negedge clk);
      for (int i = 0; i < D; i++) begin
         dut.u_cnn_top.rFrame[i] <= img[i];
         dut.u_cnn_top.u_OufBuf_DPSram_RGB565.rOufBuf[i] <= 16'hDEAD;
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int flip_at);
      done_cyc = -1;
      for (int c = 1; c <= BUDGET; c++) begin
         @(posedge clk);
         #1;
         if (c == flip_at) ireg0[0] = ~ireg0[0];
         if (done) begin
            done_cyc = c;
            break;
         end
      end
      chk({tag, "_done_lat"},
          32'(done_cyc >= D && done_cyc <= BUDGET), 32'd1);
      repeat (8) @(posedge clk);
      #1;
      chk({tag, "_done_sticky"}, 32'(done), 32'd1);
   endtask

   task automatic check_buf(input string tag);
      for (int i = 0; i < D; i++)
         chk($sformatf("%s_buf[%0d]", tag, i),
             32'(dut.u_cnn_top.u_OufBuf_DPSram_RGB565.rOufBuf[i]),
             32'(exp_q[i]));
   endtask

   initial begin
      // 1: white frame, bypass
      for (int i = 0; i < D; i++) begin
         img[i]   = 24'hFFFFFF;
         exp_q[i] = 16'hFFFF;
      end
      begin_frame(1'b1, "t1");
      wait_done("t1", 0);
      check_buf("t1");

      // 2: white frame, Gaussian with zero padding at borders
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            int e;
            e = int'(x == 0 || x == W - 1) + int'(y == 0 || y == H - 1);
            exp_q[y*W+x] = (e == 2) ? 16'h8C71 :
                           (e == 1) ? 16'hBDF7 : 16'hFFFF;
         end
      end
      begin_frame(1'b0, "t2");
      wait_done("t2", 0);
      check_buf("t2");

      // 3: single red impulse at (10,10)
      for (int i = 0; i < D; i++) begin
         img[i]   = 24'h0;
         exp_q[i] = 16'h0;
      end
      img[10*W+10]   = 24'hFF0000;
      exp_q[10*W+10] = 16'h3800;
      exp_q[9*W+10]  = 16'h1800;
      exp_q[11*W+10] = 16'h1800;
      exp_q[10*W+9]  = 16'h1800;
      exp_q[10*W+11] = 16'h1800;
      exp_q[9*W+9]   = 16'h0800;
      exp_q[9*W+11]  = 16'h0800;
      exp_q[11*W+9]  = 16'h0800;
      exp_q[11*W+11] = 16'h0800;
      begin_frame(1'b0, "t3");
      wait_done("t3", 0);
      check_buf("t3");

      // 4: random image vs golden; mode input toggles after sampling
      for (int i = 0; i < D; i++) img[i] = 24'($urandom);
      build_gauss();
      begin_frame(1'b0, "t4");
      wait_done("t4", 3);
      check_buf("t4");

      // 5: reset mid-frame for 3 cycles, then a full new frame
      for (int i = 0; i < D; i++) img[i] = 24'($urandom);
      build_gauss();
      begin_frame(1'b0, "t5");
      repeat (D / 2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("t5_mid_rst_done", 32'(done), 32'd0);
      chk("t5_mid_rst_addr", 32'(dut.u_cnn_top.p_q), 32'd0);
      @(negedge clk);
      for (int i = 0; i < D; i++)
         dut.u_cnn_top.u_OufBuf_DPSram_RGB565.rOufBuf[i] <= 16'hDEAD;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      wait_done("t5", 0);
      check_buf("t5");

      // 6: gradient, bypass, row-major addressing
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            logic [7:0] xb, yb;
            xb = 8'(x);
            yb = 8'(y);
            img[y*W+x]   = {xb, yb, 8'h55};
            exp_q[y*W+x] = {xb[7:3], yb[7:2], 5'h0A};
         end
      end
      begin_frame(1'b1, "t6");
      wait_done("t6", 0);
      check_buf("t6");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/cnn_lcd_system_top.md
Name: cnn_lcd_system_top

Overview:
- Top-level image-processing block for the camera/CNN/LCD platform, in the simulation configuration: the camera frame comes from a preloaded RGB888 frame memory, not live camera pins.
- After reset release it streams one 480x272 frame once through a 3x3 line-buffer filter, then an RGB888->RGB565 converter, into an RGB565 output frame buffer.
- It then raises a sticky done flag.
- Camera, SCCB and TFT pins are out of scope for this configuration.

Parameters:
- ADDR_W, 17, frame-memory address width.
- DATA_W, 24, source pixel width (RGB888, R in [23:16]).
- WIDTH, 480, pixels per line.
- HEIGHT, 272, lines per frame.
- DEPTH, 130560, pixels per frame (WIDTH*HEIGHT).
- INIT_FILE, "in_rgb888.txt", $readmemh hex init file for the source frame memory.

Ports:
- PL_CLK_100MHZ  input  1  system clock, 100 MHz; all logic on its rising edge.
- RstButton  input  1  reset: synchronous, active-high.
- iReg0  input  32  control: bit0 = bypass filter (1) / Gaussian (0); bits[31:1] reserved, ignored.
- iReg1  input  32  reserved, ignored.
- iReg2  input  32  reserved, ignored.
- iReg3  input  32  reserved, ignored.

Behaviour:
Reset state (RstButton=1 at a clock edge):
- Read address 0, line/column counters 0, pipeline valids 0, done_valid_reg 0.
- Output-buffer contents are not cleared.

Frame start and read:
- Processing starts automatically on the first clock with reset deasserted. No start strobe.
- Source frame memory: DEPTH x 24, row-major, address = y*WIDTH + x. Synchronous read, 1-cycle latency. One pixel is read per clock, addresses 0..DEPTH-1.

Filter (iReg0[0]=0):
- 3x3 Gaussian kernel [1 2 1; 2 4 2; 1 2 1], applied per 8-bit channel.
- Sum is 12 bits; output = sum>>4, truncated.
- Taps outside the image count as 0 (zero padding).
- Implementation: two WIDTH x 24 line buffers plus a 3x3 window register.
- Output for pixel (x,y) emerges WIDTH+1 input pixels after (x,y) enters. After the last input, the window is flushed with zero pixels so that all DEPTH outputs are produced.

Bypass (iReg0[0]=1):
- Pixel passes unchanged. Output count, order and write addresses are identical to filter mode.

Mode sampling:
- iReg0[0] is sampled once, at the first cycle after reset, and held for the frame.

RGB565 conversion:
- Output = {R[7:3], G[7:2], B[7:3]}. One pipeline register.

Output buffer:
- DEPTH x 16, row-major, write address = pixel index.
- Dual-port: port A writes, port B is a read port reserved for LCD (unused here).

Done flag:
- done_valid_reg is set in the cycle after the write of pixel DEPTH-1.
- It stays 1 until reset. It rises exactly once per frame.
- No further writes occur after done.

Reset mid-frame:
- Aborts the frame; done is cleared.
- The next release restarts from pixel 0.

Verification hooks (required hierarchy):
- Output array at u_cnn_top.u_OufBuf_DPSram_RGB565.rOufBuf[0:DEPTH-1].
- Done flag at u_cnn_top.u_RGB888ToRGB565.done_valid_reg.

Decomposition:
- Shared package: WIDTH, HEIGHT, DEPTH, ADDR_W, the RGB888/RGB565 widths, and the kernel weights.
- Top wraps one sub-module u_cnn_top, containing:
  - frame ROM
  - filter with line buffers
  - u_RGB888ToRGB565
  - u_OufBuf_DPSram_RGB565

Test Plan:
1. Uniform 0xFFFFFF frame, iReg0=1 -> all DEPTH entries 0xFFFF; done rises once.
2. Uniform 0xFFFFFF frame, iReg0=0 -> expected outputs:
   - interior pixels 0xFFFF
   - the four corners 0x8C71 (9/16 -> 143)
   - non-corner border pixels 0xBDF7 (12/16 -> 191)
3. Black frame with pixel (10,10)=0xFF0000, iReg0=0 -> expected outputs:
   - (10,10)=0x3800
   - 4-neighbours 0x1800
   - diagonals 0x0800
   - all else 0x0000
4. Golden compare: arbitrary image through the Gaussian reference model -> every rOufBuf[i] equals the golden RGB565; done within DEPTH+WIDTH+8 cycles of reset release.
5. Assert RstButton at pixel ~60000 for 3 cycles, then release -> done stays 0 until a full new frame completes; final buffer matches golden.
6. Gradient frame (R=x[7:0], G=y[7:0], B=0x55), iReg0=1 -> entry i = {x[7:3], y[7:2], 5'h0A}, confirming row-major addressing.
